// File: rtl/stage_id_pipe.sv
// rtl/stage_id_pipe.sv - RV32I decode stage with registered outputs, load-use hazard bubble and write-back bypass
//
// Purpose: decodes one fetched instruction per cycle, reads the register file
// combinationally through regfile_addr1/2, and registers the decoded fields,
// operand data and control flags for the execute stage.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en, stall, flush      stage enable, downstream hold, kill registered instruction
//   in_valid, inst        fetch slot and instruction
//   regfile_addr1/2       source register addresses (combinational from inst)
//   regfile_data1/2       register file read data
//   wb_wr/wb_addr/wb_data write-back port, bypassed into operand capture
//   stall_out             request fetch to hold its slot
//   out_*                 registered decode results

module stage_id_pipe #(
    parameter int INST_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [INST_W-1:0]     inst,
    output logic [REG_ADDR_W-1:0] regfile_addr1,
    output logic [REG_ADDR_W-1:0] regfile_addr2,
    input  logic [DATA_W-1:0]     regfile_data1,
    input  logic [DATA_W-1:0]     regfile_data2,
    input  logic                  wb_wr,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  stall_out,
    output logic                  out_valid,
    output logic                  out_reg_wr,
    output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
    output logic [REG_ADDR_W-1:0] out_reg_addr_r1,
    output logic [REG_ADDR_W-1:0] out_reg_addr_r2,
    output logic [DATA_W-1:0]     out_reg_data_r1,
    output logic [DATA_W-1:0]     out_reg_data_r2,
    output logic [DATA_W-1:0]     out_imm,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_funct3,
    output logic                  out_funct7b5,
    output logic                  out_is_load,
    output logic                  out_is_store,
    output logic                  out_is_branch,
    output logic                  out_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0]           iw;
    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] r1;
    logic [REG_ADDR_W-1:0] r2;
    logic [2:0]            funct3;
    logic                  funct7b5;

    assign iw       = inst[31:0];
    assign opcode   = iw[6:0];
    assign rd       = REG_ADDR_W'(iw[11:7]);
    assign r1       = REG_ADDR_W'(iw[19:15]);
    assign r2       = REG_ADDR_W'(iw[24:20]);
    assign funct3   = iw[14:12];
    assign funct7b5 = iw[30];

    assign regfile_addr1 = r1;
    assign regfile_addr2 = r2;

    logic signed [31:0] imm32;
    logic               dec_legal;
    logic               dec_wr_op;
    logic               dec_load;
    logic               dec_store;
    logic               dec_branch;

    always_comb begin
        imm32      = '0;
        dec_legal  = 1'b1;
        dec_wr_op  = 1'b0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm32     = {iw[31:12], 12'b0};
                dec_wr_op = 1'b1;
            end
            OP_JAL: begin
                imm32     = {{12{iw[31]}}, iw[19:12], iw[20], iw[30:21], 1'b0};
                dec_wr_op = 1'b1;
            end
            OP_JALR, OP_IMM: begin
                imm32     = {{20{iw[31]}}, iw[31:20]};
                dec_wr_op = 1'b1;
            end
            OP_LOAD: begin
                imm32     = {{20{iw[31]}}, iw[31:20]};
                dec_wr_op = 1'b1;
                dec_load  = 1'b1;
            end
            OP_STORE: begin
                imm32     = {{20{iw[31]}}, iw[31:25], iw[11:7]};
                dec_store = 1'b1;
            end
            OP_BRANCH: begin
                imm32      = {{20{iw[31]}}, iw[7], iw[30:25], iw[11:8], 1'b0};
                dec_branch = 1'b1;
            end
            OP_OP: begin
                dec_wr_op = 1'b1;
            end
            OP_MISC, OP_SYSTEM: begin
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    logic dec_wr;
    assign dec_wr = dec_wr_op && (rd != '0);

    // Operand capture: x0 reads as zero, then a same-cycle write-back wins
    // over the (not yet updated) register file contents.
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    always_comb begin
        op1 = regfile_data1;
        op2 = regfile_data2;
        if (r1 == '0) begin
            op1 = '0;
        end else if (WB_BYPASS && wb_wr && (wb_addr == r1)) begin
            op1 = wb_data;
        end
        if (r2 == '0) begin
            op2 = '0;
        end else if (WB_BYPASS && wb_wr && (wb_addr == r2)) begin
            op2 = wb_data;
        end
    end

    // A load in the output register whose result the incoming instruction
    // needs: insert one bubble so the load data reaches the bypass path.
    logic hazard;
    assign hazard = out_valid && out_is_load && (out_reg_addr_rd != '0) && in_valid &&
                    ((r1 == out_reg_addr_rd) || (r2 == out_reg_addr_rd));

    assign stall_out = hazard || stall || !en;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_reg_wr      <= 1'b0;
            out_reg_addr_rd <= '0;
            out_reg_addr_r1 <= '0;
            out_reg_addr_r2 <= '0;
            out_reg_data_r1 <= '0;
            out_reg_data_r2 <= '0;
            out_imm         <= '0;
            out_opcode      <= '0;
            out_funct3      <= '0;
            out_funct7b5    <= 1'b0;
            out_is_load     <= 1'b0;
            out_is_store    <= 1'b0;
            out_is_branch   <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!en || stall) begin
            out_valid <= out_valid;
        end else if (hazard) begin
            out_valid <= 1'b0;
        end else begin
            out_valid       <= in_valid;
            out_reg_wr      <= in_valid && dec_legal && dec_wr;
            out_reg_addr_rd <= rd;
            out_reg_addr_r1 <= r1;
            out_reg_addr_r2 <= r2;
            out_reg_data_r1 <= op1;
            out_reg_data_r2 <= op2;
            out_imm         <= DATA_W'(imm32);
            out_opcode      <= opcode;
            out_funct3      <= funct3;
            out_funct7b5    <= funct7b5;
            out_is_load     <= in_valid && dec_load;
            out_is_store    <= in_valid && dec_store;
            out_is_branch   <= in_valid && dec_branch;
            out_illegal     <= in_valid && !dec_legal;
        end
    end

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb/tb_stage_id_pipe.sv - directed scoreboard bench for stage_id_pipe

module tb_stage_id_pipe;

    logic        clk = 1'b0;
    logic        rst, en, stall, flush, in_valid;
    logic [31:0] inst;
    logic [4:0]  regfile_addr1, regfile_addr2;
    logic [31:0] regfile_data1, regfile_data2;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_out, out_valid, out_reg_wr;
    logic [4:0]  out_reg_addr_rd, out_reg_addr_r1, out_reg_addr_r2;
    logic [31:0] out_reg_data_r1, out_reg_data_r2, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5, out_is_load, out_is_store, out_is_branch, out_illegal;

    logic [4:0]  b_addr1, b_addr2, b_rd, b_r1, b_r2;
    logic        b_stall_out, b_valid, b_wr, b_f7, b_ld, b_st, b_br, b_il;
    logic [31:0] b_d1, b_d2, b_imm;
    logic [6:0]  b_opc;
    logic [2:0]  b_f3;

    always #5 clk = ~clk;

    stage_id_pipe #(.INST_W(32), .DATA_W(32), .REG_ADDR_W(5), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush),
        .in_valid(in_valid), .inst(inst),
        .regfile_addr1(regfile_addr1), .regfile_addr2(regfile_addr2),
        .regfile_data1(regfile_data1), .regfile_data2(regfile_data2),
        .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_out(stall_out), .out_valid(out_valid), .out_reg_wr(out_reg_wr),
        .out_reg_addr_rd(out_reg_addr_rd), .out_reg_addr_r1(out_reg_addr_r1),
        .out_reg_addr_r2(out_reg_addr_r2), .out_reg_data_r1(out_reg_data_r1),
        .out_reg_data_r2(out_reg_data_r2), .out_imm(out_imm), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_is_load(out_is_load),
        .out_is_store(out_is_store), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
    );

    stage_id_pipe #(.INST_W(32), .DATA_W(32), .REG_ADDR_W(5), .WB_BYPASS(1'b0)) dut_nobyp (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush),
        .in_valid(in_valid), .inst(inst),
        .regfile_addr1(b_addr1), .regfile_addr2(b_addr2),
        .regfile_data1(regfile_data1), .regfile_data2(regfile_data2),
        .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_out(b_stall_out), .out_valid(b_valid), .out_reg_wr(b_wr),
        .out_reg_addr_rd(b_rd), .out_reg_addr_r1(b_r1), .out_reg_addr_r2(b_r2),
        .out_reg_data_r1(b_d1), .out_reg_data_r2(b_d2), .out_imm(b_imm), .out_opcode(b_opc),
        .out_funct3(b_f3), .out_funct7b5(b_f7), .out_is_load(b_ld),
        .out_is_store(b_st), .out_is_branch(b_br), .out_illegal(b_il)
    );

    typedef struct {
        logic        v, wr;
        logic [4:0]  rd, r1, r2;
        logic [31:0] imm, d1, d2;
        logic        ld, st, br, il;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(logic v, logic wr, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] imm, logic [31:0] d1, logic [31:0] d2,
                                logic ld, logic st, logic br, logic il);
        exp_t e;
        e.v = v; e.wr = wr; e.rd = rd; e.r1 = r1; e.r2 = r2;
        e.imm = imm; e.d1 = d1; e.d2 = d2;
        e.ld = ld; e.st = st; e.br = br; e.il = il;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid"},  out_valid,       e.v);
            chk({tag, ".reg_wr"}, out_reg_wr,      e.wr);
            chk({tag, ".rd"},     out_reg_addr_rd, e.rd);
            chk({tag, ".r1"},     out_reg_addr_r1, e.r1);
            chk({tag, ".r2"},     out_reg_addr_r2, e.r2);
            chk({tag, ".imm"},    out_imm,         e.imm);
            chk({tag, ".d1"},     out_reg_data_r1, e.d1);
            chk({tag, ".d2"},     out_reg_data_r2, e.d2);
            chk({tag, ".load"},   out_is_load,     e.ld);
            chk({tag, ".store"},  out_is_store,    e.st);
            chk({tag, ".branch"}, out_is_branch,   e.br);
            chk({tag, ".illegal"}, out_illegal,    e.il);
        end
    endtask

    // Inputs are already driven; push the expectation, cross one edge, compare.
    task automatic step(input string tag, input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    localparam logic [31:0] ADDI  = 32'hFFF00293;
    localparam logic [31:0] LW    = 32'h0000A303;
    localparam logic [31:0] ADD   = 32'h002303B3;
    localparam logic [31:0] SW    = 32'h00322423;
    localparam logic [31:0] BEQ   = 32'hFE000EE3;
    localparam logic [31:0] ADDIB = 32'h00018093;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] RF1   = 32'h11111111;
    localparam logic [31:0] RF2   = 32'h22222222;

    exp_t zero_e, addi_e, lw_e, add_e;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        zero_e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addi_e = mk(1, 1, 5, 0, 31, 32'hFFFFFFFF, 0, RF2, 0, 0, 0, 0);
        lw_e   = mk(1, 1, 6, 1, 0, 0, RF1, 0, 1, 0, 0, 0);
        add_e  = mk(1, 1, 7, 6, 2, 0, RF1, RF2, 0, 0, 0, 0);

        rst = 1; en = 1; stall = 0; flush = 0; in_valid = 1; inst = ADDI;
        regfile_data1 = RF1; regfile_data2 = RF2;
        wb_wr = 0; wb_addr = 0; wb_data = 0;
        #1;
        step("reset0", zero_e);
        step("reset1", zero_e);
        chk("reset.stall_out", stall_out, 0);

        rst = 0; in_valid = 1; inst = ADDI;
        step("addi", addi_e);

        in_valid = 0;
        step("addi_nov", mk(0, 0, 5, 0, 31, 32'hFFFFFFFF, 0, RF2, 0, 0, 0, 0));

        in_valid = 1; inst = LW;
        step("lw", lw_e);
        inst = ADD;
        #1;
        chk("hazard.stall_out", stall_out, 1);
        step("bubble", mk(0, 1, 6, 1, 0, 0, RF1, 0, 1, 0, 0, 0));
        chk("bubble.stall_out", stall_out, 0);
        step("add", add_e);
        inst = SW;
        step("add_thru_sw", mk(1, 0, 8, 4, 3, 8, RF1, RF2, 0, 1, 0, 0));

        inst = BEQ;
        step("beq", mk(1, 0, 29, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0));

        inst = ADDIB; regfile_data1 = 0; wb_wr = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
        step("bypass", mk(1, 1, 1, 3, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        chk("nobypass.d1", b_d1, 0);
        regfile_data1 = RF1; wb_wr = 0;

        inst = ADDI;
        step("addi2", addi_e);
        stall = 1; inst = SW;
        #1;
        chk("stall.stall_out", stall_out, 1);
        step("stall_hold", addi_e);
        flush = 1;
        step("stall_flush", mk(0, 1, 5, 0, 31, 32'hFFFFFFFF, 0, RF2, 0, 0, 0, 0));
        stall = 0; flush = 0;

        inst = SW;
        step("sw", mk(1, 0, 8, 4, 3, 8, RF1, RF2, 0, 1, 0, 0));
        en = 0; inst = ADDI;
        #1;
        chk("en0.stall_out", stall_out, 1);
        step("en0_hold", mk(1, 0, 8, 4, 3, 8, RF1, RF2, 0, 1, 0, 0));
        en = 1;

        inst = ILL;
        step("illegal", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        inst = ADDI;
        step("addi3", addi_e);
        rst = 1; stall = 1; flush = 1;
        step("rst_mid", zero_e);
        rst = 0; stall = 0; flush = 0;

        inst = LW;
        step("lw2", lw_e);
        inst = ADD; rst = 1;
        step("rst_hazard", zero_e);
        rst = 0;
        #1;
        chk("post_rst.stall_out", stall_out, 0);
        step("add_after_rst", add_e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
